ps2_rx_fifo: RTL and testbench

- Next-generation PS/2 receiver, fully synchronous to the system clock. No logic is clocked by the PS/2 clock.
- Adds the following over the single-byte receiver:
  - parametrised glitch filter
  - odd-parity and stop-bit checking
  - frame timeout
  - a parametrised receive FIFO, so the keyboard/host logic can drain bursts of scancodes at its own pace.
- Sits between the PS/2 connector pins and the keyboard matrix translator.

---
 rtl/ps2_rx_fifo.sv | 174 +++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: clk-synchronous PS/2 receiver (glitch filter, parity/stop/timeout checks) feeding a FWFT byte FIFO.
// Define PS2_EXTCODE_EN to fold E0/F0 prefixes into per-entry ext/rel flags.
module ps2_rx_fifo #(
  parameter int FILTER_CYCLES   = 1000,
  parameter int TIMEOUT_CYCLES  = 50000,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ps2_clk,
  input  logic                     ps2_data,
  input  logic                     rd_en,
  input  logic                     clr_err,
  output logic [7:0]               dout,
`ifdef PS2_EXTCODE_EN
  output logic                     dout_ext,
  output logic                     dout_rel,
`endif
  output logic                     empty,
  output logic [FIFO_DEPTH_LOG2:0] count,
  output logic                     overflow,
  output logic                     parity_err,
  output logic                     frame_err
);
  localparam int FW = $clog2(FILTER_CYCLES + 2);
  localparam logic [FW-1:0] F_MAX = FW'(FILTER_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES - 1);
  localparam int CW = FIFO_DEPTH_LOG2 + 1;
`ifdef PS2_EXTCODE_EN
  localparam int EW = 10;
`else
  localparam int EW = 8;
`endif
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t r_state, w_state_n;
  logic r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2, r_fprev, r_filt, r_filt_d;
  logic [FW-1:0] r_fcnt;
  logic [TW-1:0] r_tcnt;
  logic [2:0] r_bit, w_bit_n;
  logic [7:0] r_shift, w_shift_n;
  logic r_par, w_par_n, w_strobe, w_good, w_perr, w_ferr, w_store;
  logic r_push, r_perr, r_ferr, r_ovf, w_full, w_pop, w_push;
  logic [EW-1:0] r_wdata, w_entry, w_head;
  logic [EW-1:0] r_mem [2**FIFO_DEPTH_LOG2];
  logic [FIFO_DEPTH_LOG2-1:0] r_wp, r_rp;
  logic [CW-1:0] r_count;
  assign w_strobe = r_filt_d & ~r_filt;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
      r_fprev  <= 1'b1;
      r_filt   <= 1'b1;
      r_filt_d <= 1'b1;
      r_fcnt   <= '0;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
      r_fprev  <= r_clk_s2;
      r_fcnt   <= (r_clk_s2 != r_fprev) ? '0 : (r_fcnt == F_MAX) ? r_fcnt : r_fcnt + 1'b1;
      if (r_clk_s2 == r_fprev && r_fcnt == F_MAX) r_filt <= r_clk_s2;
      r_filt_d <= r_filt;
    end
  end
  always_comb begin
    w_state_n = r_state;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_par_n   = r_par;
    w_good    = 1'b0;
    w_perr    = 1'b0;
    w_ferr    = 1'b0;
    if (w_strobe) begin
      case (r_state)
        IDLE: if (!r_dat_s2) begin
          w_state_n = DATA;
          w_bit_n   = '0;
        end
        DATA: begin
          w_shift_n = {r_dat_s2, r_shift[7:1]};
          w_bit_n   = r_bit + 1'b1;
          w_state_n = (r_bit == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
          w_par_n   = r_dat_s2;
          w_state_n = STOP;
        end
        default: begin
          // a bad stop bit masks any parity result
          w_state_n = IDLE;
          w_ferr    = ~r_dat_s2;
          w_good    = r_dat_s2 & (^{r_shift, r_par});
          w_perr    = r_dat_s2 & ~(^{r_shift, r_par});
        end
      endcase
    end else if (r_state != IDLE && r_tcnt == T_MAX) begin
      w_state_n = IDLE;
      w_ferr    = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tcnt  <= '0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_push  <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
      r_par   <= w_par_n;
      r_tcnt  <= (r_state == IDLE || w_strobe) ? '0 : r_tcnt + 1'b1;
      r_perr  <= w_perr;
      r_ferr  <= w_ferr;
      r_push  <= w_store;
      r_wdata <= w_entry;
    end
  end
`ifdef PS2_EXTCODE_EN
  logic r_pext, r_prel, w_is_e0, w_is_f0;
  assign w_is_e0 = (r_shift == 8'hE0);
  assign w_is_f0 = (r_shift == 8'hF0);
  assign w_store = w_good & ~w_is_e0 & ~w_is_f0;
  assign w_entry = {r_pext, r_prel, r_shift};
  always_ff @(posedge clk) begin
    if (reset || w_perr || w_ferr) begin
      r_pext <= 1'b0;
      r_prel <= 1'b0;
    end else if (w_good) begin
      r_pext <= w_is_e0 | (w_is_f0 & r_pext);
      r_prel <= w_is_f0 | (w_is_e0 & r_prel);
    end
  end
  assign dout_ext = ~empty & w_head[9];
  assign dout_rel = ~empty & w_head[8];
`else
  assign w_store = w_good;
  assign w_entry = r_shift;
`endif
  assign empty  = (r_count == '0);
  assign w_full = r_count[FIFO_DEPTH_LOG2];
  assign w_pop  = rd_en & ~empty;
  assign w_push = r_push & (~w_full | w_pop);
  assign w_head = r_mem[r_rp];
  always_ff @(posedge clk) if (w_push) r_mem[r_wp] <= r_wdata;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      r_ovf   <= (r_push & w_full & ~w_pop) | (r_ovf & ~clr_err);
    end
  end
  assign dout       = empty ? 8'h00 : w_head[7:0];
  assign count      = r_count;
  assign overflow   = r_ovf;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: directed frame table plus hand-timed corner sequences for ps2_rx_fifo.
module tb_ps2_rx_fifo;
  localparam int HALF = 20;
  logic clk = 1'b0;
  logic reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1, rd_en = 1'b0, clr_err = 1'b0;
  logic [7:0] dout;
  logic empty, overflow, parity_err, frame_err;
  logic [2:0] count;
`ifdef PS2_EXTCODE_EN
  logic dout_ext, dout_rel;
`endif
  int chk = 0, errs = 0, perr_cyc = 0, ferr_cyc = 0, p0, f0;
  typedef struct {
    logic [7:0] data;
    bit par_ok;
    bit stop;
    bit pop;
    int cnt;
    logic [7:0] dout;
    int perr;
    int ferr;
  } vec_t;
  vec_t tv [7];

  ps2_rx_fifo #(.FILTER_CYCLES(4), .TIMEOUT_CYCLES(200), .FIFO_DEPTH_LOG2(2)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd_en(rd_en), .clr_err(clr_err), .dout(dout),
`ifdef PS2_EXTCODE_EN
    .dout_ext(dout_ext), .dout_rel(dout_rel),
`endif
    .empty(empty), .count(count), .overflow(overflow),
    .parity_err(parity_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(negedge clk) begin
    perr_cyc += (parity_err === 1'b1) ? 1 : 0;
    ferr_cyc += (frame_err === 1'b1) ? 1 : 0;
  end
  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [10:0] frame_bits(input logic [7:0] d, input bit par_ok, input bit stop);
    return {stop, (~^d) ^ ~par_ok, d, 1'b0};
  endfunction
  task automatic send_frame(input logic [7:0] d, input bit par_ok, input bit stop, input int nbits);
    logic [10:0] b;
    b = frame_bits(d, par_ok, stop);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = b[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_cyc(HALF);
  endtask
  // stop-bit fall at P0; strobe lands in cycle P8, the FIFO write in cycle P9
  task automatic send_pop(input logic [7:0] d);
    send_frame(d, 1'b1, 1'b1, 10);
    ps2_clk = 1'b0;
    wait_cyc(8);
    rd_en = 1'b1;
    wait_cyc(1);
    rd_en = 1'b0;
    wait_cyc(HALF - 9);
    ps2_clk = 1'b1;
    wait_cyc(HALF);
  endtask
  task automatic pop_expect(input string name, input logic [7:0] exp);
    check(name, dout, exp);
    rd_en = 1'b1;
    wait_cyc(1);
    rd_en = 1'b0;
  endtask

  initial begin
    tv = '{
      '{8'h1C, 1'b1, 1'b1, 1'b0, 1, 8'h1C, 0, 0},
      '{8'h1C, 1'b0, 1'b1, 1'b0, 1, 8'h1C, 1, 0},
      '{8'h1C, 1'b1, 1'b0, 1'b0, 1, 8'h1C, 0, 1},
      '{8'h5A, 1'b0, 1'b0, 1'b0, 1, 8'h1C, 0, 1},
      '{8'h5A, 1'b1, 1'b1, 1'b1, 2, 8'h1C, 0, 0},
      '{8'hFF, 1'b1, 1'b1, 1'b0, 2, 8'h5A, 0, 0},
      '{8'h00, 1'b1, 1'b1, 1'b0, 3, 8'h5A, 0, 0}
    };
    wait_cyc(5);
    reset = 1'b0;
    check("rst_empty", empty, 1);
    check("rst_count", count, 0);
    check("rst_dout", dout, 0);
    check("rst_overflow", overflow, 0);
    check("rst_errs", {parity_err, frame_err}, 0);
    wait_cyc(10);
    for (int i = 0; i < 7; i++) begin
      p0 = perr_cyc;
      f0 = ferr_cyc;
      send_frame(tv[i].data, tv[i].par_ok, tv[i].stop, 11);
      check($sformatf("vec%0d_count", i), count, tv[i].cnt);
      check($sformatf("vec%0d_dout", i), dout, tv[i].dout);
      check($sformatf("vec%0d_perr", i), perr_cyc - p0, tv[i].perr);
      check($sformatf("vec%0d_ferr", i), ferr_cyc - f0, tv[i].ferr);
      if (tv[i].pop) begin
        rd_en = 1'b1;
        wait_cyc(1);
        rd_en = 1'b0;
        check($sformatf("vec%0d_popcount", i), count, tv[i].cnt - 1);
      end
    end
    pop_expect("drain0", 8'h5A);
    pop_expect("drain1", 8'hFF);
    pop_expect("drain2", 8'h00);
    check("drain_empty", empty, 1);
    rd_en = 1'b1;
    wait_cyc(3);
    rd_en = 1'b0;
    check("underflow_count", count, 0);
    check("underflow_empty", empty, 1);

    f0 = ferr_cyc;
    ps2_data = 1'b0;
    ps2_clk = 1'b0;
    wait_cyc(2);
    ps2_clk = 1'b1;
    wait_cyc(250);
    ps2_data = 1'b1;
    wait_cyc(5);
    check("glitch_no_ferr", ferr_cyc - f0, 0);
    send_frame(8'h33, 1'b1, 1'b1, 11);
    check("glitch_next_count", count, 1);
    pop_expect("glitch_next_dout", 8'h33);

    p0 = perr_cyc;
    f0 = ferr_cyc;
    send_frame(8'h5A, 1'b1, 1'b1, 4);
    wait_cyc(250);
    check("timeout_ferr", ferr_cyc - f0, 1);
    check("timeout_perr", perr_cyc - p0, 0);
    check("timeout_count", count, 0);
    send_frame(8'h5A, 1'b1, 1'b1, 11);
    check("after_timeout_count", count, 1);
    pop_expect("after_timeout_dout", 8'h5A);

    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b1, 11);
    check("ovf_count", count, 4);
    check("ovf_flag", overflow, 1);
    for (int i = 1; i <= 4; i++) pop_expect($sformatf("ovf_read%0d", i), 8'(i));
    check("ovf_sticky", overflow, 1);
    check("ovf_empty", empty, 1);
    clr_err = 1'b1;
    wait_cyc(1);
    clr_err = 1'b0;
    check("ovf_cleared", overflow, 0);

    send_frame(8'h20, 1'b1, 1'b1, 11);
    send_pop(8'h21);
    check("pp1_count", count, 1);
    check("pp1_dout", dout, 8'h21);
    pop_expect("pp1_drain", 8'h21);

    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b1, 11);
    send_pop(8'h14);
    check("ppfull_count", count, 4);
    check("ppfull_overflow", overflow, 0);
    for (int i = 1; i <= 4; i++) pop_expect($sformatf("ppfull_read%0d", i), 8'h10 + 8'(i));

    send_frame(8'h40, 1'b1, 1'b1, 11);
    p0 = perr_cyc;
    f0 = ferr_cyc;
    send_frame(8'h29, 1'b1, 1'b1, 5);
    reset = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    check("midrst_empty", empty, 1);
    check("midrst_count", count, 0);
    check("midrst_dout", dout, 0);
    wait_cyc(300);
    check("midrst_no_errs", (perr_cyc - p0) + (ferr_cyc - f0), 0);
    send_frame(8'h29, 1'b1, 1'b1, 11);
    check("midrst_next_count", count, 1);
    pop_expect("midrst_next_dout", 8'h29);

`ifdef PS2_EXTCODE_EN
    send_frame(8'hE0, 1'b1, 1'b1, 11);
    send_frame(8'hF0, 1'b1, 1'b1, 11);
    send_frame(8'h75, 1'b1, 1'b1, 11);
    check("ext_count", count, 1);
    check("ext_flags", {dout_ext, dout_rel}, 2'b11);
    pop_expect("ext_dout", 8'h75);
    send_frame(8'h75, 1'b1, 1'b1, 11);
    check("plain_flags", {dout_ext, dout_rel}, 2'b00);
    pop_expect("plain_dout", 8'h75);
`endif
    $display("CHECKS %0d ERRORS %0d", chk, errs);
    $finish;
  end
endmodule
